// File: rtl/capture_write_counter_if.sv
// capture_write_counter_if
//   Bundles the capture-FSM side of the write counter: enable/clear/decimation
//   from the control FSM, and the BRAM write strobe/address, full pulse,
//   sample count and busy flag returned by the counter.
//   master : the capture control FSM (drives enable, clear, decimation)
//   slave  : capture_write_counter (drives BRAM strobe/address and status)
interface capture_write_counter_if #(
  parameter int ADDR_W  = 10,
  parameter int DECIM_W = 8
);
  logic               i_write_ena;
  logic               i_clear;
  logic [DECIM_W-1:0] i_decim;
  logic               o_bram_we;
  logic [ADDR_W-1:0]  o_bram_addr;
  logic               o_write_full;
  logic [ADDR_W:0]    o_count;
  logic               o_busy;

  modport master (
    output i_write_ena, i_clear, i_decim,
    input  o_bram_we, o_bram_addr, o_write_full, o_count, o_busy
  );

  modport slave (
    input  i_write_ena, i_clear, i_decim,
    output o_bram_we, o_bram_addr, o_write_full, o_count, o_busy
  );
endinterface

// File: rtl/capture_write_counter.sv
// capture_write_counter
//   Write-address generator and fill monitor for the capture BRAM. Turns the
//   capture FSM's write enable into a decimated, registered BRAM write strobe
//   and address, pulses o_write_full with the write to address DEPTH-1, and
//   counts the samples stored in the current or last run.
//
// Ports
//   clk   : system clock, rising edge
//   i_rst : asynchronous active-high reset
//   bus   : capture_write_counter_if.slave
//           i_write_ena, i_clear, i_decim in; o_bram_we, o_bram_addr,
//           o_write_full, o_count, o_busy out
//
// state | meaning
// IDLE  | waiting for enable; next enable latches decimation and starts a run
// RUN   | writing one sample every decim_q+1 enabled cycles
// DONE  | DEPTH samples stored; writes blocked until enable drops
module capture_write_counter #(
  parameter int ADDR_W  = 10,
  parameter int DEPTH   = 1024,
  parameter int DECIM_W = 8
) (
  input  logic                    clk,
  input  logic                    i_rst,
  capture_write_counter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t             state_q;
  state_t             state_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [DECIM_W-1:0] decim_q;
  logic [DECIM_W-1:0] presc_q;
  logic [ADDR_W:0]    count_q;
  logic               we_q;
  logic               full_q;
  logic [ADDR_W-1:0]  bram_addr_q;
  logic               write_go;
  logic               last_write;

  // A sample is taken only on the prescaler's zero phase, so i_decim=0
  // writes on every enabled cycle.
  assign write_go   = (state_q == ST_RUN) && bus.i_write_ena && (presc_q == '0);
  assign last_write = write_go && (addr_q == LAST_ADDR);

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.i_clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.i_write_ena) state_d = ST_RUN;
        ST_RUN:  if (last_write)      state_d = ST_DONE;
        ST_DONE: if (!bus.i_write_ena) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      addr_q      <= '0;
      decim_q     <= '0;
      presc_q     <= '0;
      count_q     <= '0;
      we_q        <= 1'b0;
      full_q      <= 1'b0;
      bram_addr_q <= '0;
    end else if (bus.i_clear) begin
      // Abort: drop any pending strobe and rewind, but keep the count so
      // software can see how far the aborted run got.
      addr_q  <= '0;
      presc_q <= '0;
      we_q    <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      we_q   <= write_go;
      full_q <= last_write;
      case (state_q)
        ST_IDLE: begin
          if (bus.i_write_ena) begin
            decim_q <= bus.i_decim;
            count_q <= '0;
            presc_q <= '0;
            addr_q  <= '0;
          end
        end
        ST_RUN: begin
          if (bus.i_write_ena) begin
            presc_q <= (presc_q == decim_q) ? '0 : presc_q + 1'b1;
          end
          if (write_go) begin
            bram_addr_q <= addr_q;
            count_q     <= count_q + 1'b1;
            // Rewind on the last write so the address never steps past
            // DEPTH-1, even when DEPTH is not a power of two.
            addr_q      <= last_write ? '0 : addr_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (!bus.i_write_ena) addr_q <= '0;
        end
        default: addr_q <= '0;
      endcase
    end
  end

  always_comb begin
    bus.o_busy       = (state_q == ST_RUN);
    bus.o_bram_we    = we_q;
    bus.o_bram_addr  = bram_addr_q;
    bus.o_write_full = full_q;
    bus.o_count      = count_q;
  end

endmodule

// File: tb/tb_capture_write_counter.sv
module tb_capture_write_counter;

  localparam int ADDR_W  = 4;
  localparam int DEPTH   = 8;
  localparam int DECIM_W = 3;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  typedef struct {
    int addr;
    int full;
    int count;
  } wr_t;

  logic clk = 1'b0;
  logic i_rst = 1'b0;

  capture_write_counter_if #(.ADDR_W(ADDR_W), .DECIM_W(DECIM_W)) bus ();

  capture_write_counter #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .DECIM_W(DECIM_W)
  ) dut (
    .clk  (clk),
    .i_rst(i_rst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a run stores the sample on every (d+1)-th enabled RUN
  // cycle, counting from the first one; the k-th stored sample goes to
  // address k. The run ends after DEPTH samples.
  wr_t sb[$];
  int  m_mode;
  int  m_d;
  int  m_en;
  int  m_nwr;
  int  m_cnt;

  always @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      m_mode = M_IDLE;
      m_d    = 0;
      m_en   = 0;
      m_nwr  = 0;
      m_cnt  = 0;
      sb.delete();
    end else if (bus.i_clear) begin
      m_mode = M_IDLE;
      m_en   = 0;
      m_nwr  = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (bus.i_write_ena) begin
          m_mode = M_RUN;
          m_d    = int'(bus.i_decim);
          m_en   = 0;
          m_nwr  = 0;
          m_cnt  = 0;
        end
        M_RUN: if (bus.i_write_ena) begin
          if ((m_en % (m_d + 1)) == 0) begin
            wr_t w;
            w.addr  = m_nwr;
            w.full  = (m_nwr == DEPTH - 1) ? 1 : 0;
            w.count = m_cnt + 1;
            sb.push_back(w);
            m_cnt++;
            m_nwr++;
            if (m_nwr == DEPTH) m_mode = M_DONE;
          end
          m_en++;
        end
        M_DONE: if (!bus.i_write_ena) m_mode = M_IDLE;
        default: m_mode = M_IDLE;
      endcase
    end
  end

  // Monitor: pops an expected write whenever the DUT shows a strobe.
  always @(negedge clk) begin
    if (bus.o_bram_we) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        wr_t w;
        w = sb.pop_front();
        chk("bram_addr", int'(bus.o_bram_addr), w.addr);
        chk("write_full", int'(bus.o_write_full), w.full);
        chk("count_at_write", int'(bus.o_count), w.count);
      end
    end else begin
      if (sb.size() != 0) begin
        void'(sb.pop_front());
        chk("missing_write", 0, 1);
      end
      chk("full_without_we", int'(bus.o_write_full), 0);
    end
    chk("busy", int'(bus.o_busy), (m_mode == M_RUN) ? 1 : 0);
    chk("count", int'(bus.o_count), m_cnt);
  end

  task automatic cyc(input logic e, input logic c, input int d, input int n);
    for (int k = 0; k < n; k++) begin
      bus.i_write_ena = e;
      bus.i_clear     = c;
      bus.i_decim     = DECIM_W'(d);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bus.i_write_ena = 1'b0;
    bus.i_clear     = 1'b0;
    bus.i_decim     = '0;

    #1 i_rst = 1'b1;
    #2;
    chk("rst_we", int'(bus.o_bram_we), 0);
    chk("rst_addr", int'(bus.o_bram_addr), 0);
    chk("rst_full", int'(bus.o_write_full), 0);
    chk("rst_count", int'(bus.o_count), 0);
    chk("rst_busy", int'(bus.o_busy), 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #3 i_rst = 1'b0;
    @(posedge clk);
    #1;

    // Full run, no decimation, enable held past the full pulse.
    cyc(1'b1, 1'b0, 0, 13);
    cyc(1'b0, 1'b0, 0, 2);
    chk("count_after_full_run", int'(bus.o_count), DEPTH);

    // Decimation by 3 with a 5-cycle pause right after the write to addr 2.
    cyc(1'b1, 1'b0, 2, 8);
    cyc(1'b0, 1'b0, 5, 5);
    cyc(1'b1, 1'b0, 7, 20);
    cyc(1'b0, 1'b0, 0, 2);

    // Abort after three writes, then a fresh run.
    cyc(1'b1, 1'b0, 0, 4);
    cyc(1'b1, 1'b1, 0, 1);
    cyc(1'b0, 1'b0, 0, 1);
    chk("count_held_after_clear", int'(bus.o_count), 3);
    chk("busy_after_clear", int'(bus.o_busy), 0);
    cyc(1'b1, 1'b0, 0, 11);
    cyc(1'b0, 1'b0, 0, 2);

    // Asynchronous reset between clock edges in the middle of a run.
    cyc(1'b1, 1'b0, 1, 6);
    chk("count_before_rst_nonzero", (int'(bus.o_count) != 0) ? 1 : 0, 1);
    #2 i_rst = 1'b1;
    #1;
    chk("async_rst_we", int'(bus.o_bram_we), 0);
    chk("async_rst_full", int'(bus.o_write_full), 0);
    chk("async_rst_busy", int'(bus.o_busy), 0);
    chk("async_rst_count", int'(bus.o_count), 0);
    @(posedge clk);
    #1;
    bus.i_write_ena = 1'b0;
    @(posedge clk);
    #1 i_rst = 1'b0;
    @(posedge clk);
    #1;

    // Randomised traffic: mostly enabled, occasional drops and clears,
    // decimation changed freely (only latched at run start).
    for (int i = 0; i < 2500; i++) begin
      cyc(($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
          int'($urandom_range(0, 3)), 1);
    end
    cyc(1'b0, 1'b0, 0, 3);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/capture_write_counter.md
Name: capture_write_counter

Overview:
- Write-address generator and fill monitor for the capture BRAM.
- Sits directly downstream of the capture control FSM: consumes its write enable, produces the BRAM write strobe and address, and returns the write-full pulse the FSM uses to leave its write state.
- Supports programmable decimation and reports the number of samples stored per capture run.

Parameters:
- ADDR_W, 10, BRAM address width.
- DEPTH, 1024, number of samples per capture run; must satisfy 2 <= DEPTH <= 2**ADDR_W.
- DECIM_W, 8, width of the decimation ratio input.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_write_ena  in  1  write enable from the capture control FSM.
- i_clear  in  1  synchronous abort/clear of the current run.
- i_decim  in  DECIM_W  decimation ratio; one sample is written every i_decim+1 enabled cycles.
- o_bram_we  out  1  BRAM write strobe, registered.
- o_bram_addr  out  ADDR_W  BRAM write address, registered; valid when o_bram_we=1.
- o_write_full  out  1  one-cycle pulse coincident with the write to address DEPTH-1.
- o_count  out  ADDR_W+1  samples written in the current or last run.
- o_busy  out  1  high in RUN state.

Behaviour:
- Reset (async, immediate): all outputs 0; state IDLE; address, prescaler and count at 0.
- States:
  - IDLE: i_write_ena=1 -> RUN; latch i_decim into decim_q; clear o_count; prescaler=0.
  - RUN: writes samples as described below; after the write to DEPTH-1 -> DONE.
  - DONE: writes blocked; i_write_ena=0 -> IDLE with address reset to 0; otherwise stay. Extra enable cycles from the FSM after the full pulse are absorbed here.
- i_clear=1 (any state): next cycle state=IDLE, address=0, prescaler=0, o_bram_we=0, o_write_full=0. o_count holds. i_clear has priority over all other events.
- Write strobe in RUN:
  - A write is issued when i_write_ena=1 and prescaler==0.
  - The registered strobe appears one cycle later: o_bram_we=1 and o_bram_addr = current address.
  - The address then increments by 1.
  - Prescaler counts 0..decim_q and wraps to 0. i_decim=0 gives one write per enabled cycle.
- Pause: i_write_ena=0 in RUN -> no write; prescaler and address hold; resume continues from the held values. State stays RUN.
- Full:
  - The write to address DEPTH-1 asserts o_write_full=1 in the same cycle as that o_bram_we.
  - The pulse lasts exactly one cycle; state becomes DONE.
  - The address never wraps within a run; no write ever targets an address >= DEPTH.
- o_count: increments with each o_bram_we; equals DEPTH at the end of a full run. Holds through DONE and IDLE until the next run starts.
- i_decim changes during RUN are ignored until the next IDLE->RUN transition.
- o_busy = (state==RUN).
- Reset mid-run: outputs drop asynchronously; no partial-state recovery.

Test Plan:
- DEPTH=8, i_decim=0, i_write_ena held high -> o_bram_we high for 8 consecutive cycles, addresses 0..7; o_write_full=1 only with addr 7; o_count=8; o_busy falls.
- i_decim=2, DEPTH=4, enable held -> writes every 3rd cycle at addresses 0,1,2,3; full pulse with addr 3; o_count=4.
- i_write_ena dropped for 5 cycles after the write to addr 2 -> no strobes during the gap; next write is addr 3 and the prescaler phase is preserved.
- After full, i_write_ena held 3 extra cycles -> no o_bram_we, no second full pulse; after enable low, a new run starts writing at addr 0.
- i_clear pulsed after 3 writes -> next cycle idle, addr 0, o_count=3 held; next enable restarts at addr 0 with o_count reset to 0.
- i_rst asserted mid-run between clock edges -> o_bram_we, o_write_full, o_busy and o_count go to 0 before the next edge.
